// File: rtl/sram_mem_initiator.sv
// sram_mem_initiator: bridges a valid/ready native memory bus onto a byte-write SRAM port.
// Rev 1.0 - initial release.
`default_nettype none

module sram_mem_initiator #(
  parameter int                    NB_COL     = 4,
  parameter int                    COL_WIDTH  = 8,
  parameter int                    RAM_DEPTH  = 8192,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                                  clka,
  input  logic                                  rsta,
  input  logic                                  mem_valid,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]           mem_wdata,
  input  logic [NB_COL-1:0]                     mem_wstrb,
  output logic                                  mem_ready,
  output logic [NB_COL*COL_WIDTH-1:0]           mem_rdata,
  output logic                                  mem_err,
  output logic [clogb2(RAM_DEPTH-1)-1:0]        sram_addra,
  output logic [NB_COL*COL_WIDTH-1:0]           sram_dina,
  output logic [NB_COL-1:0]                     sram_wea,
  output logic                                  sram_ena,
  input  logic [NB_COL*COL_WIDTH-1:0]           sram_douta
);

  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    for (n = 0; d > 0; n++) d = d >> 1;
    return n;
  endfunction

  localparam int                  AW        = clogb2(RAM_DEPTH - 1);
  localparam int                  DW        = NB_COL * COL_WIDTH;
  localparam int                  LB        = $clog2(NB_COL);
  localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(RAM_DEPTH * NB_COL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   addra_q;
  logic [DW-1:0]   dina_q;
  logic [NB_COL-1:0] wea_q;
  logic            ena_q;

  // One extra bit so an address below BASE_ADDR cannot wrap into the window.
  logic [ADDR_WIDTH:0] off;
  logic                in_range;
  logic [AW-1:0]       word_addr;

  assign off       = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign in_range  = (mem_addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign word_addr = AW'(off >> LB);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      wea_q   <= '0;
      ena_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            if (in_range) begin
              ena_q   <= 1'b1;
              addra_q <= word_addr;
              dina_q  <= mem_wdata;
              wea_q   <= mem_wstrb;
              state_q <= ACCESS;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              ready_q <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        ACCESS: begin
          ena_q <= 1'b0;
          wea_q <= '0;
          if (|wea_q) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // douta is only valid for this one edge; the SRAM clears it next.
          rdata_q <= sram_douta;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ready  = ready_q;
  assign mem_err    = err_q;
  assign mem_rdata  = rdata_q;
  assign sram_addra = addra_q;
  assign sram_dina  = dina_q;
  assign sram_wea   = wea_q;
  assign sram_ena   = ena_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_initiator.sv
// tb_sram_mem_initiator: directed bench with a transaction-level model and per-cycle compare.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_sram_mem_initiator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb, sram_wea;
  logic        mem_ready, mem_err, sram_ena;
  logic [12:0] sram_addra;
  logic [31:0] sram_dina, sram_douta;

  sram_mem_initiator dut (
    .clka(clk), .rsta(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .sram_addra(sram_addra), .sram_dina(sram_dina), .sram_wea(sram_wea),
    .sram_ena(sram_ena), .sram_douta(sram_douta)
  );

  // Second instance with a non-zero window base.
  logic        v2, rdy2, err2, ena2;
  logic [31:0] a2, wd2, rd2, dina2;
  logic [31:0] douta2 = 32'd0;
  logic [3:0]  ws2, wea2;
  logic [12:0] addra2;

  sram_mem_initiator #(.BASE_ADDR(32'h0000_1000)) dut2 (
    .clka(clk), .rsta(rst),
    .mem_valid(v2), .mem_addr(a2), .mem_wdata(wd2), .mem_wstrb(ws2),
    .mem_ready(rdy2), .mem_rdata(rd2), .mem_err(err2),
    .sram_addra(addra2), .sram_dina(dina2), .sram_wea(wea2),
    .sram_ena(ena2), .sram_douta(douta2)
  );

  // Byte-write SRAM with 1-cycle read latency; douta returns to 0 when not enabled.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (sram_ena) begin
      for (int b = 0; b < 4; b++)
        if (sram_wea[b]) ram[sram_addra][8*b +: 8] <= sram_dina[8*b +: 8];
      sram_douta <= ram[sram_addra];
    end else begin
      sram_douta <= 32'd0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  logic [31:0] shadow [0:8191];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          exp_acc_cyc = -1, exp_ready_cyc = -1;
  logic [12:0] exp_addra;
  logic [3:0]  exp_wea;
  logic [31:0] exp_dina, exp_rdata;
  logic        exp_err;
  logic [31:0] obs_rdata;
  logic [12:0] obs_addra;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_ready", 32'(mem_ready), 32'(cyc == exp_ready_cyc));
      chk("sram_ena", 32'(sram_ena), 32'(cyc == exp_acc_cyc));
      chk("wea_without_ena", 32'(sram_wea & {4{~sram_ena}}), 32'd0);
      if (cyc == exp_acc_cyc) begin
        chk("sram_addra", 32'(sram_addra), 32'(exp_addra));
        chk("sram_wea", 32'(sram_wea), 32'(exp_wea));
        chk("sram_dina", sram_dina, exp_dina);
        obs_addra = sram_addra;
      end
      if (cyc == exp_ready_cyc) begin
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        chk("mem_rdata", mem_rdata, exp_rdata);
        obs_rdata = mem_rdata;
      end
    end
  end

  // Issue one request; called just after a posedge. Inputs are scrambled once sampled.
  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input bit drop);
    longint off;
    bit     in;
    int     w, lat;
    off = longint'(a);
    in  = (off < 32768);
    w   = in ? int'(off >> 2) : 0;
    lat = !in ? 1 : ((ws != 4'd0) ? 2 : 3);
    exp_acc_cyc   = in ? cyc + 1 : -1;
    exp_ready_cyc = cyc + lat;
    exp_addra     = 13'(w);
    exp_wea       = ws;
    exp_dina      = wd;
    exp_err       = !in;
    exp_rdata     = (in && ws == 4'd0) ? shadow[w] : 32'd0;
    if (in)
      for (int b = 0; b < 4; b++)
        if (ws[b]) shadow[w][8*b +: 8] = wd[8*b +: 8];
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    @(posedge clk); #1;
    mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    if (drop) mem_valid = 1'b0;
    repeat (lat) @(posedge clk);
    #1 mem_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin ram[i] = 32'd0; shadow[i] = 32'd0; end
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    v2 = 1'b0; a2 = '0; wd2 = '0; ws2 = '0;

    // Async reset mid-cycle, before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addra", 32'(sram_addra), 32'd0);
    chk("rst_dina", sram_dina, 32'd0);
    chk("rst_wea", 32'(sram_wea), 32'd0);
    chk("rst_ena", 32'(sram_ena), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    chk("lit_wr_addra", 32'(obs_addra), 32'd4);
    req(32'h10, 32'h0, 4'h0, 1'b0);
    chk("lit_rd_data", obs_rdata, 32'hDEADBEEF);
    req(32'h14, 32'h0, 4'h0, 1'b0);
    chk("lit_b2b_addra", 32'(obs_addra), 32'd5);
    req(32'h10, 32'h00AA0000, 4'b0100, 1'b1);
    req(32'h12, 32'h0, 4'h0, 1'b1);
    chk("lit_byte_merge", obs_rdata, 32'hDEAABEEF);
    req(32'h7FFC, 32'h11223344, 4'hF, 1'b0);
    req(32'h7FFC, 32'h0, 4'h0, 1'b0);
    chk("lit_top_addra", 32'(obs_addra), 32'd8191);
    chk("lit_top_data", obs_rdata, 32'h11223344);
    req(32'h8000, 32'h0, 4'h0, 1'b0);
    req(32'hFFFF_FFFC, 32'h5555AAAA, 4'hF, 1'b0);
    req(32'h10, 32'h0, 4'h0, 1'b0);
    chk("lit_err_no_write", obs_rdata, 32'hDEAABEEF);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a write must abort it
    req(32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
    chk_en = 1'b0;
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ena_before", 32'(sram_ena), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ena", 32'(sram_ena), 32'd0);
    chk("abort_wea", 32'(sram_wea), 32'd0);
    chk("abort_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(mem_ready), 32'd0);
    end
    @(posedge clk); #1;
    exp_acc_cyc = -1; exp_ready_cyc = -1;
    chk_en = 1'b1;
    req(32'h20, 32'h0, 4'h0, 1'b0);
    chk("lit_abort_prior", obs_rdata, 32'hCAFEF00D);

    // Window based at 0x1000
    v2 = 1'b1; a2 = 32'h0FFC; ws2 = 4'h0;
    @(posedge clk); @(negedge clk);
    chk("b2_below_ready", 32'(rdy2), 32'd1);
    chk("b2_below_err", 32'(err2), 32'd1);
    chk("b2_below_ena", 32'(ena2), 32'd0);
    chk("b2_below_rdata", rd2, 32'd0);
    @(posedge clk); #1 v2 = 1'b0;
    @(negedge clk);
    chk("b2_ready_clear", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    v2 = 1'b1; a2 = 32'h1008; wd2 = 32'hA5A5_0F0F; ws2 = 4'hF;
    @(posedge clk); @(negedge clk);
    chk("b2_wr_ena", 32'(ena2), 32'd1);
    chk("b2_wr_addra", 32'(addra2), 32'd2);
    chk("b2_wr_ready_early", 32'(rdy2), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("b2_wr_ready", 32'(rdy2), 32'd1);
    chk("b2_wr_err", 32'(err2), 32'd0);
    @(posedge clk); #1 v2 = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
